// File: rtl/count_tx_pkg.sv
// ----------------------------------------------------------------------------
// count_tx_pkg
// Shared definitions for the counter-readout UART transmitter.
//   SYNC_BYTE    : first byte of every frame; the receiver aligns on it.
//   tx_state_t   : transmitter FSM states.
//   frame_cycles : clock cycles one complete frame occupies on the line.
// ----------------------------------------------------------------------------
package count_tx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // One frame is the sync byte, nbytes data bytes and the checksum byte.
  // Each byte is 10 bits on the line (start, 8 data, stop).
  function automatic int frame_cycles(input int nbytes, input int clks_per_bit);
    return (nbytes + 2) * 10 * clks_per_bit;
  endfunction

endpackage : count_tx_pkg

// File: rtl/count_baud_gen.sv
// ----------------------------------------------------------------------------
// count_baud_gen
// Bit-time reference for the transmitter.
//   clk     : clock
//   rst     : synchronous active-high reset
//   restart : forces the count back to zero so a new frame starts in phase
//   tick    : one-cycle pulse on the last cycle of every CLKS_PER_BIT period
// ----------------------------------------------------------------------------
module count_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule : count_baud_gen

// File: rtl/count_uart_tx.sv
// ----------------------------------------------------------------------------
// count_uart_tx
// Serialises a counter snapshot as one UART frame:
//   0xA5, data bytes MSB first, XOR checksum of the data bytes; 8N1, LSB first,
//   bytes sent back to back with no idle gap.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset (aborts any frame in flight)
//   send_i  : snapshot valid
//   data_i  : snapshot value, captured only on accept (send_i && ready_o)
//   ready_o : high when a snapshot can be accepted
//   busy_o  : high while a frame is in flight
//   tx_o    : registered serial line, idles high
// ----------------------------------------------------------------------------
module count_uart_tx
  import count_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int WIDTH        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             tx_o
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BIW    = $clog2(NBYTES + 2);
  localparam logic [BIW-1:0] LAST_IDX = BIW'(NBYTES + 1);

  tx_state_t        state_q, state_d;
  logic [BIW-1:0]   byte_idx_q, byte_idx_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       csum_q, csum_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             tx_q, tx_d;

  logic             tick;
  logic             restart;
  logic [BIW-1:0]   next_idx;
  logic [7:0]       next_byte;
  logic             next_is_data;

  count_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // Byte that follows the current one: a data byte (MSB first) or, after the
  // last data byte, the running checksum.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    next_idx     = byte_idx_q + BIW'(1);
    next_is_data = (next_idx <= BIW'(NBYTES));
    next_byte    = csum_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (next_idx == BIW'(i + 1)) begin
        next_byte = data_q[(NBYTES-1-i)*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    data_d     = data_q;
    tx_d       = tx_q;
    restart    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (send_i) begin
          state_d    = START;
          data_d     = data_i;
          shift_d    = SYNC_BYTE;
          byte_idx_d = '0;
          bit_cnt_d  = '0;
          csum_d     = '0;
          tx_d       = 1'b0;
          restart    = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        if (tick) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end else begin
            // Checksum accumulates as each data byte enters the shifter.
            state_d    = START;
            byte_idx_d = next_idx;
            shift_d    = next_byte;
            tx_d       = 1'b0;
            if (next_is_data) begin
              csum_d = csum_q ^ next_byte;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      tx_q       <= tx_d;
    end
  end

  // NOTE: the snapshot register has no reset; it is always loaded on accept
  // before any of its bytes can reach the line.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign ready_o = (state_q == IDLE) && !rst;
  assign busy_o  = (state_q != IDLE);
  assign tx_o    = tx_q;

endmodule : count_uart_tx
